// File: rtl/bus_matrix.sv
// bus_matrix: round-robin NM-master / NS-slave shared bus. Grant is 1 cycle after request and read data 1 cycle after select.
// The owner keeps the bus until it drops m_req (no preemption). Define BUS_DECERR_EN to enable the m_err decode-error pulse.
module bus_matrix #(
  parameter int NM     = 2,
  parameter int NS     = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NM-1:0]        m_req,
  input  logic [NM-1:0]        m_wr,
  input  logic [NM*ADDR_W-1:0] m_addr,
  input  logic [NM*DATA_W-1:0] m_dout,
  output logic [NM-1:0]        m_grant,
  output logic [DATA_W-1:0]    m_din,
  output logic                 m_err,
  output logic [NS-1:0]        s_sel,
  output logic                 s_wr,
  output logic [ADDR_W-1:0]    s_addr,
  output logic [DATA_W-1:0]    s_din,
  input  logic [NS*DATA_W-1:0] s_dout
);

  localparam int OW = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  logic [0:0]        state;
  logic [OW-1:0]     owner;
  logic [OW-1:0]     winner;
  logic              found;
  logic              own_req;
  logic              own_wr;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_dout;
  logic              xfer;
  logic              arb;
  logic [2:0]        idx;
  logic              rd_vld;
  logic [2:0]        rd_idx;

  always_comb begin
    own_req  = 1'b0;
    own_wr   = 1'b0;
    own_addr = '0;
    own_dout = '0;
    for (int i = 0; i < NM; i++) begin
      if (OW'(i) == owner) begin
        own_req  = m_req[i];
        own_wr   = m_wr[i];
        own_addr = m_addr[i*ADDR_W +: ADDR_W];
        own_dout = m_dout[i*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer = (state == ST_OWNED) && own_req;
  assign arb  = (state == ST_IDLE) || !own_req;
  assign idx  = own_addr[ADDR_W-1 -: 3];

  // Search starts just after the current/last owner, so it is checked last.
  always_comb begin
    winner = owner;
    found  = 1'b0;
    for (int i = 1; i <= NM; i++) begin
      int cand;
      cand = (int'(owner) + i) % NM;
      if (!found && m_req[cand]) begin
        found  = 1'b1;
        winner = OW'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      owner  <= OW'(NM - 1);
      rd_vld <= 1'b0;
      rd_idx <= '0;
    end else begin
      if (arb) begin
        if (found) begin
          state <= ST_OWNED;
          owner <= winner;
        end else begin
          state <= ST_IDLE;
        end
      end
      rd_vld <= xfer && !own_wr && (int'(idx) < NS);
      rd_idx <= idx;
    end
  end

  always_comb begin
    m_grant = '0;
    for (int i = 0; i < NM; i++) begin
      if ((state == ST_OWNED) && (OW'(i) == owner)) m_grant[i] = 1'b1;
    end
  end

  always_comb begin
    s_sel = '0;
    for (int k = 0; k < NS; k++) begin
      if (xfer && (int'(idx) == k)) s_sel[k] = 1'b1;
    end
  end

  assign s_wr   = xfer ? own_wr   : 1'b0;
  assign s_addr = xfer ? own_addr : '0;
  assign s_din  = xfer ? own_dout : '0;

  always_comb begin
    m_din = '0;
    for (int k = 0; k < NS; k++) begin
      if (rd_vld && (int'(rd_idx) == k)) m_din = s_dout[k*DATA_W +: DATA_W];
    end
  end

`ifdef BUS_DECERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) m_err <= 1'b0;
    else       m_err <= xfer && (int'(idx) >= NS);
  end
`else
  assign m_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_matrix.sv
// Directed bench for bus_matrix (NM=2, NS=2, ADDR_W=16, DATA_W=64) with a small synchronous-RAM slave model.
module tb_bus_matrix;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    m_req;
  logic [1:0]    m_wr;
  logic [31:0]   m_addr;
  logic [127:0]  m_dout;
  logic [1:0]    m_grant;
  logic [63:0]   m_din;
  logic          m_err;
  logic [1:0]    s_sel;
  logic          s_wr;
  logic [15:0]   s_addr;
  logic [63:0]   s_din;
  logic [127:0]  s_dout;
  logic [63:0]   mem [2][16];

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [63:0] WDATA = 64'h1122334455667788;

  bus_matrix #(.NM(2), .NS(2), .ADDR_W(16), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
    .m_grant(m_grant), .m_din(m_din), .m_err(m_err),
    .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din),
    .s_dout(s_dout)
  );

  always #5 clk = ~clk;

  // Slave model: synchronous RAM, read data registered on the select edge; stale output otherwise.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 16; j++) mem[k][j] <= 64'hA5A5_0000_0000_0000 | 64'(k << 8) | 64'(j);
        s_dout[k*64 +: 64] <= 64'hDEAD_BEEF_0BAD_F00D;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (s_sel[k]) begin
          if (s_wr) mem[k][s_addr[3:0]] <= s_din;
          else      s_dout[k*64 +: 64] <= mem[k][s_addr[3:0]];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_req = '0; m_wr = '0; m_addr = '0; m_dout = '0;
    repeat (2) cyc();
    m_req = 2'b01;
    #1;
    chk("rst_grant", 64'(m_grant), 64'h0);
    chk("rst_sel",   64'(s_sel),   64'h0);
    chk("rst_din",   m_din,        64'h0);
    chk("rst_err",   64'(m_err),   64'h0);
    chk("rst_addr",  64'(s_addr),  64'h0);
    chk("rst_wr",    64'(s_wr),    64'h0);

    // Single master write then read of slave 0
    cyc(); reset = 1'b0; m_req = 2'b01; m_wr = 2'b01;
    m_addr = {16'h0000, 16'h0008}; m_dout = {64'h0, WDATA};
    #1;
    chk("c0_grant", 64'(m_grant), 64'h0);
    cyc(); #1;
    chk("c1_grant", 64'(m_grant), 64'h1);
    chk("c1_sel",   64'(s_sel),   64'h1);
    chk("c1_wr",    64'(s_wr),    64'h1);
    chk("c1_addr",  64'(s_addr),  64'h0008);
    chk("c1_sdin",  s_din,        WDATA);
    cyc(); m_wr = 2'b00; #1;
    chk("c2_sel",   64'(s_sel),   64'h1);
    chk("c2_wr",    64'(s_wr),    64'h0);
    chk("c2_din",   m_din,        64'h0);
    cyc(); m_req = 2'b00; #1;
    chk("c3_din",   m_din,        WDATA);
    chk("c3_sel",   64'(s_sel),   64'h0);
    chk("c3_addr",  64'(s_addr),  64'h0);
    chk("c3_sdin",  s_din,        64'h0);
    chk("c3_grant", 64'(m_grant), 64'h1);

    // Master 1 reads slave 1, then back-to-back unmapped read
    cyc(); m_req = 2'b10; m_addr = {16'h2000, 16'h0000}; #1;
    chk("c4_grant", 64'(m_grant), 64'h0);
    chk("c4_din",   m_din,        64'h0);
    cyc(); #1;
    chk("c5_grant", 64'(m_grant), 64'h2);
    chk("c5_sel",   64'(s_sel),   64'h2);
    chk("c5_addr",  64'(s_addr),  64'h2000);
    cyc(); m_addr = {16'hE000, 16'h0000}; #1;
    chk("c6_din",   m_din,        64'hA5A5_0000_0000_0100);
    chk("c6_sel",   64'(s_sel),   64'h0);
    chk("c6_addr",  64'(s_addr),  64'hE000);
    cyc(); m_req = 2'b00; #1;
    chk("c7_din",   m_din,        64'h0);
`ifdef BUS_DECERR_EN
    chk("c7_err",   64'(m_err),   64'h1);
`else
    chk("c7_err",   64'(m_err),   64'h0);
`endif

    // Read accepted, then reset asserted in the following cycle
    cyc(); m_req = 2'b01; m_addr = {16'h0000, 16'h0003}; #1;
    chk("c8_grant", 64'(m_grant), 64'h0);
    chk("c8_err",   64'(m_err),   64'h0);
    cyc(); #1;
    chk("c9_grant", 64'(m_grant), 64'h1);
    chk("c9_sel",   64'(s_sel),   64'h1);
    cyc(); #1;
    chk("c10_din",  m_din,        64'hA5A5_0000_0000_0003);
    reset = 1'b1; m_req = 2'b11; #1;
    chk("mid_grant", 64'(m_grant), 64'h0);
    chk("mid_sel",   64'(s_sel),   64'h0);
    chk("mid_din",   m_din,        64'h0);

    // Contention from reset: master0, handover to master1, back to master0
    cyc(); cyc(); reset = 1'b0; #1;
    chk("r0_grant", 64'(m_grant), 64'h0);
    cyc(); #1;
    chk("r1_grant", 64'(m_grant), 64'h1);
    m_req = 2'b10;
    cyc(); #1;
    chk("r2_grant", 64'(m_grant), 64'h2);
    m_req = 2'b11;
    cyc(); #1;
    chk("r3_grant", 64'(m_grant), 64'h2);
    m_req = 2'b01;
    cyc(); #1;
    chk("r4_grant", 64'(m_grant), 64'h1);
    cyc(); m_req = 2'b00;
    cyc(); #1;
    chk("r6_grant", 64'(m_grant), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
